// File: rtl/maple_rx_buffer.sv
// maple_rx_buffer: receive-side frame FIFO for the Maple deserialiser with
// frame length, XOR checksum and overflow tracking on an FWFT read port.
module maple_rx_buffer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [7:0]        in_data,
  input  logic              in_produce,
  input  logic              in_start,
  input  logic              in_end,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              pkt_busy,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              checksum_ok,
  output logic              overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic              start_prev_q, start_prev_d, end_prev_q, end_prev_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_nx, len_q, len_d;
  logic [7:0]        xor_q, xor_d, xor_nx;
  logic              done_q, done_d, ck_q, ck_d, ovf_q, ovf_d;
  logic [7:0]        mem_q [2**ADDR_W];
  logic              start_edge, end_edge, recv, byte_in, do_wr, do_rd, mem_we;

  assign start_edge = in_start & ~start_prev_q;
  assign end_edge   = in_end & ~end_prev_q;
  assign recv       = state_q == RECV;
  assign byte_in    = in_produce & recv & ~start_edge;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign do_wr      = byte_in & (~full_q | rd_en);
  assign do_rd      = rd_en & ~empty_q;
  assign mem_we     = do_wr & ~clear;
  assign cnt_nx     = byte_in ? (cnt_q == '1 ? cnt_q : cnt_q + 1'b1) : cnt_q;
  assign xor_nx     = byte_in ? xor_q ^ in_data : xor_q;

  always_comb begin
    state_d      = state_q;
    start_prev_d = in_start;
    end_prev_d   = in_end;
    wr_ptr_d     = wr_ptr_q + ADDR_W'(do_wr);
    rd_ptr_d     = rd_ptr_q + ADDR_W'(do_rd);
    level_d      = level_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);
    cnt_d        = cnt_nx;
    xor_d        = xor_nx;
    len_d        = len_q;
    done_d       = done_q;
    ck_d         = ck_q;
    ovf_d        = ovf_q | (byte_in & ~do_wr);
    if (clear) begin
      state_d      = IDLE;
      start_prev_d = 1'b0;
      end_prev_d   = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      cnt_d        = '0;
      xor_d        = '0;
      len_d        = '0;
      done_d       = 1'b0;
      ck_d         = 1'b0;
      ovf_d        = 1'b0;
    end else if (start_edge) begin
      state_d  = RECV;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = '0;
      xor_d    = '0;
      done_d   = 1'b0;
      ck_d     = 1'b0;
      ovf_d    = 1'b0;
    end else if (recv && end_edge) begin
      state_d = DONE;
      len_d   = cnt_nx;
      ck_d    = (xor_nx == 8'd0) && (cnt_nx != '0);
      done_d  = 1'b1;
    end
    empty_d = level_d == '0;
    full_d  = level_d == DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      end_prev_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      cnt_q        <= '0;
      xor_q        <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      ck_q         <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      end_prev_q   <= end_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      len_q        <= len_d;
      done_q       <= done_d;
      ck_q         <= ck_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_data;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign level       = level_q;
  assign pkt_busy    = recv;
  assign pkt_done    = done_q;
  assign pkt_len     = len_q;
  assign checksum_ok = ck_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_maple_rx_buffer.sv
// tb_maple_rx_buffer: directed scenario tests for maple_rx_buffer at a
// 4-byte FIFO depth so that full/overflow/wrap are easy to reach.
module tb_maple_rx_buffer;
  logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_produce = 1'b0, in_start = 1'b0, in_end = 1'b0, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, pkt_busy, pkt_done, checksum_ok, overflow;
  logic [2:0] level;
  logic [9:0] pkt_len;
  logic [18:0] st;
  localparam logic [18:0] RST_ST = {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0};
  int total = 0, bad = 0;

  maple_rx_buffer #(.ADDR_W(2), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data),
    .in_produce(in_produce), .in_start(in_start), .in_end(in_end), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .pkt_busy(pkt_busy), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .checksum_ok(checksum_ok), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign st = {empty, full, level, pkt_busy, pkt_done, pkt_len, checksum_ok, overflow};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    in_start = 1'b1;
    cyc();
    in_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    in_produce = 1'b1;
    in_data = b;
    cyc();
    in_produce = 1'b0;
  endtask

  task automatic end_frame;
    in_end = 1'b1;
    cyc();
    in_end = 1'b0;
  endtask

  task automatic pop;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (st !== RST_ST) begin bad++; $display("FAIL reset_state got=%h exp=%h", st, RST_ST); end
    rst_n = 1'b1;
    cyc();
    push(8'h5A);
    total++; if (st !== RST_ST) begin bad++; $display("FAIL idle_byte_ignored got=%h exp=%h", st, RST_ST); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h04, 8'h07};
    start_frame();
    total++; if (pkt_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", pkt_busy); end
    push(8'h01);
    total++; if (empty !== 1'b0 || rd_data !== 8'h01) begin bad++; $display("FAIL basic_fwft got=%b/%h exp=0/01", empty, rd_data); end
    push(8'h02); push(8'h04); push(8'h07);
    end_frame();
    total++; if (pkt_done !== 1'b1 || pkt_len !== 10'd4 || checksum_ok !== 1'b1 || level !== 3'd4 || pkt_busy !== 1'b0)
      begin bad++; $display("FAIL basic_status got=done%b len%0d ck%b lvl%0d busy%b exp=done1 len4 ck1 lvl4 busy0", pkt_done, pkt_len, checksum_ok, level, pkt_busy); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data !== exp[i]) begin bad++; $display("FAIL basic_read%0d got=%h exp=%h", i, rd_data, exp[i]); end
      pop();
    end
    total++; if (empty !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL basic_empty got=%b/%0d exp=1/0", empty, level); end
  endtask

  task automatic test_checksum;
    start_frame();
    push(8'h10); push(8'h20); push(8'h31);
    end_frame();
    total++; if (pkt_len !== 10'd3 || checksum_ok !== 1'b0 || pkt_done !== 1'b1)
      begin bad++; $display("FAIL cksum_bad got=len%0d ck%b done%b exp=len3 ck0 done1", pkt_len, checksum_ok, pkt_done); end
    start_frame();
    end_frame();
    total++; if (pkt_len !== 10'd0 || checksum_ok !== 1'b0 || pkt_done !== 1'b1 || empty !== 1'b1)
      begin bad++; $display("FAIL cksum_empty got=len%0d ck%b done%b e%b exp=len0 ck0 done1 e1", pkt_len, checksum_ok, pkt_done, empty); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA6};
    start_frame();
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    total++; if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_full got=f%b l%0d o%b exp=f1 l4 o0", full, level, overflow); end
    push(8'hA4); push(8'hA5);
    total++; if (overflow !== 1'b1 || level !== 3'd4) begin bad++; $display("FAIL ovf_drop got=o%b l%0d exp=o1 l4", overflow, level); end
    in_produce = 1'b1; in_data = 8'hA6; rd_en = 1'b1;
    cyc();
    in_produce = 1'b0; rd_en = 1'b0;
    total++; if (level !== 3'd4 || full !== 1'b1 || rd_data !== 8'hA1) begin bad++; $display("FAIL ovf_wr_rd got=l%0d f%b d%h exp=l4 f1 dA1", level, full, rd_data); end
    end_frame();
    total++; if (pkt_len !== 10'd7 || overflow !== 1'b1 || pkt_done !== 1'b1) begin bad++; $display("FAIL ovf_len got=len%0d o%b d%b exp=len7 o1 d1", pkt_len, overflow, pkt_done); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data !== exp[i]) begin bad++; $display("FAIL ovf_read%0d got=%h exp=%h", i, rd_data, exp[i]); end
      pop();
    end
    push(8'hEE);
    total++; if (level !== 3'd0 || pkt_len !== 10'd7 || empty !== 1'b1) begin bad++; $display("FAIL done_byte_ignored got=l%0d len%0d e%b exp=l0 len7 e1", level, pkt_len, empty); end
  endtask

  task automatic test_end_byte;
    start_frame();
    push(8'h55);
    in_produce = 1'b1; in_data = 8'h66; in_end = 1'b1;
    cyc();
    in_produce = 1'b0; in_end = 1'b0;
    total++; if (pkt_len !== 10'd2 || level !== 3'd2 || checksum_ok !== 1'b0 || pkt_done !== 1'b1)
      begin bad++; $display("FAIL end_byte got=len%0d l%0d ck%b d%b exp=len2 l2 ck0 d1", pkt_len, level, checksum_ok, pkt_done); end
    pop();
    total++; if (rd_data !== 8'h66) begin bad++; $display("FAIL end_byte_data got=%h exp=66", rd_data); end
  endtask

  task automatic test_abort;
    start_frame();
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    total++; if (overflow !== 1'b1 || level !== 3'd4) begin bad++; $display("FAIL abort_pre got=o%b l%0d exp=o1 l4", overflow, level); end
    start_frame();
    total++; if (level !== 3'd0 || pkt_done !== 1'b0 || overflow !== 1'b0 || pkt_busy !== 1'b1 || empty !== 1'b1)
      begin bad++; $display("FAIL abort_flush got=l%0d d%b o%b b%b e%b exp=l0 d0 o0 b1 e1", level, pkt_done, overflow, pkt_busy, empty); end
    push(8'h42); push(8'h42);
    end_frame();
    total++; if (pkt_len !== 10'd2 || level !== 3'd2 || checksum_ok !== 1'b1 || rd_data !== 8'h42)
      begin bad++; $display("FAIL abort_new got=len%0d l%0d ck%b d%h exp=len2 l2 ck1 d42", pkt_len, level, checksum_ok, rd_data); end
  endtask

  task automatic test_async_reset;
    start_frame();
    push(8'h11); push(8'h22);
    #3 rst_n = 1'b0;
    #1;
    total++; if (st !== RST_ST) begin bad++; $display("FAIL async_reset got=%h exp=%h", st, RST_ST); end
    #1 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_clear;
    start_frame();
    push(8'h99);
    end_frame();
    total++; if (pkt_done !== 1'b1 || level !== 3'd1) begin bad++; $display("FAIL clear_pre got=d%b l%0d exp=d1 l1", pkt_done, level); end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    total++; if (st !== RST_ST) begin bad++; $display("FAIL clear_state got=%h exp=%h", st, RST_ST); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      start_frame();
      for (int i = 0; i < 3; i++) push(8'(k * 16 + i));
      end_frame();
      for (int i = 0; i < 3; i++) begin
        total++; if (rd_data !== 8'(k * 16 + i)) begin bad++; $display("FAIL b2b_f%0d_b%0d got=%h exp=%h", k, i, rd_data, 8'(k * 16 + i)); end
        pop();
      end
    end
    start_frame();
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 3; i++) push(8'(8'hD0 + i));
    total++; if (level !== 3'd3) begin bad++; $display("FAIL wrap_level got=%0d exp=3", level); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_data !== 8'(8'hD0 + i)) begin bad++; $display("FAIL wrap_b%0d got=%h exp=%h", i, rd_data, 8'(8'hD0 + i)); end
      pop();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_overflow();
    test_end_byte();
    test_abort();
    test_async_reset();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
